// File: rtl/v6_pulse_gen_pkg.sv
// ----------------------------------------------------------------------------
// v6_pulse_gen_pkg
// Shared settings for the v6 synthetic pulse source.
//   - SIZE_FILTER_DATA : sample width shared with the v6 shaping filter
//   - PG_DELAY_W       : default width of the per-pulse start delay
//   - PG_RISE_SHIFT, PG_DECAY_SHIFT, PG_FIFO_DEPTH : default pulse-generator settings
//   - pg_state_t       : pulse FSM state encoding
//   - pg_cmd_t         : queued pulse command {amp, delay}
// ----------------------------------------------------------------------------
package v6_pulse_gen_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int PG_DELAY_W       = 16;
    localparam int PG_RISE_SHIFT    = 2;
    localparam int PG_DECAY_SHIFT   = 4;
    localparam int PG_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        PG_IDLE = 2'd0,
        PG_WAIT = 2'd1,
        PG_RISE = 2'd2
    } pg_state_t;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic        [PG_DELAY_W-1:0]       delay;
    } pg_cmd_t;

endpackage

// File: rtl/v6_pulse_fifo.sv
// ----------------------------------------------------------------------------
// v6_pulse_fifo
// Synchronous command queue for the pulse generator.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (flushes the queue)
//   push        : write push_data this edge (ignored when full, unless popping too)
//   push_data   : command to enqueue
//   pop         : drop the head entry this edge (ignored when empty)
//   pop_data    : head entry (valid when !empty)
//   full, empty : occupancy flags
// Handshake: the caller qualifies push/pop; a push and a pop on the same edge
// are both honoured even when the queue is full.
// ----------------------------------------------------------------------------
module v6_pulse_fifo
    import v6_pulse_gen_pkg::*;
#(
    parameter type T     = pg_cmd_t,
    parameter int  DEPTH = PG_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_pop;
    logic           do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/v6_pulse_gen.sv
// ----------------------------------------------------------------------------
// v6_pulse_gen
// Synthetic detector-pulse source. Queued (amplitude, delay) commands become
// pulses with a linear rise of 2**RISE_SHIFT samples and an exponential tail;
// tails of successive pulses pile up. One sample per sample_en strobe.
// Optional feature macro: PULSE_GEN_NOISE_EN adds 4-bit LFSR noise to the
// output only (never to the accumulator).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   sample_en     : sample strobe; datapath and FSM advance only when high
//   cmd_valid/cmd_ready/cmd_amp/cmd_delay : command input
//     valid/ready: a command transfers on a clk edge where cmd_valid && cmd_ready;
//     cmd_ready = queue not full and not in reset; cmd_* must hold until transfer.
//   output_data   : signed saturated sample, registered on the strobe edge
//   output_valid  : registered sample_en
//   busy          : FSM not idle or queue non-empty
//   sat_flag      : sticky saturation indicator, cleared only by reset
//   dbg_state     : current FSM state (pg_state_t encoding)
// ----------------------------------------------------------------------------
module v6_pulse_gen
    import v6_pulse_gen_pkg::*;
#(
    parameter int DATA_W      = SIZE_FILTER_DATA,
    parameter int DELAY_W     = PG_DELAY_W,
    parameter int RISE_SHIFT  = PG_RISE_SHIFT,
    parameter int DECAY_SHIFT = PG_DECAY_SHIFT,
    parameter int FIFO_DEPTH  = PG_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DATA_W-1:0]   cmd_amp,
    input  logic [DELAY_W-1:0]  cmd_delay,
    output logic [DATA_W-1:0]   output_data,
    output logic                output_valid,
    output logic                busy,
    output logic                sat_flag,
    output logic [1:0]          dbg_state
);

    localparam int ACC_W = DATA_W + 2;

    localparam logic [1:0] S_IDLE = 2'(PG_IDLE);
    localparam logic [1:0] S_WAIT = 2'(PG_WAIT);
    localparam logic [1:0] S_RISE = 2'(PG_RISE);

    localparam logic signed [ACC_W-1:0] MAX_V = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {3'b111, {(DATA_W-1){1'b0}}};
    localparam logic [RISE_SHIFT:0]     RISE_LAST = (RISE_SHIFT+1)'((1 << RISE_SHIFT) - 1);

    typedef struct packed {
        logic [DATA_W-1:0]  amp;
        logic [DELAY_W-1:0] delay;
    } cmd_t;

    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
        if (v > MAX_V)      return MAX_V;
        else if (v < MIN_V) return MIN_V;
        else                return v;
    endfunction

    logic [1:0]                 state;
    logic [DELAY_W-1:0]         cnt;
    logic [RISE_SHIFT:0]        rcnt;
    logic signed [DATA_W-1:0]   step;
    logic signed [ACC_W-1:0]    acc;

    cmd_t                       fifo_in;
    cmd_t                       fifo_out;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic signed [DATA_W-1:0]   pop_amp;

    logic signed [ACC_W-1:0]    dec;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    acc_clamped;
    logic signed [ACC_W-1:0]    out_pre;
    logic signed [ACC_W-1:0]    out_clamped;
    logic                       sat_hit;

    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = sample_en && (state == S_IDLE) && !fifo_empty;
    assign fifo_in   = '{amp: cmd_amp, delay: cmd_delay};
    assign pop_amp   = fifo_out.amp;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign dbg_state = state;

    v6_pulse_fifo #(
        .T     (cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decay term. Arithmetic shift alone would stall a small positive tail
    // forever, so force a minimum step of 1 while acc is positive.
    always_comb begin
        dec = acc >>> DECAY_SHIFT;
        if (dec == '0 && !acc[ACC_W-1] && acc != '0) dec = ACC_W'(1);
        acc_next = acc - dec;
        if (state == S_RISE) acc_next = acc_next + {{2{step[DATA_W-1]}}, step};
        acc_clamped = clamp(acc_next);
    end

`ifdef PULSE_GEN_NOISE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    // Fibonacci LFSR, taps 16,14,13,11. Output uses the value it steps to
    // on this strobe.
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign out_pre   = acc_next + {{(ACC_W-4){lfsr_next[3]}}, lfsr_next[3:0]};

    always_ff @(posedge clk) begin
        if (reset)          lfsr <= 16'hACE1;
        else if (sample_en) lfsr <= lfsr_next;
    end
`else
    assign out_pre = acc_next;
`endif

    assign out_clamped = clamp(out_pre);
    assign sat_hit     = (out_clamped != out_pre) || (acc_clamped != acc_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rcnt         <= '0;
            step         <= '0;
            acc          <= '0;
            output_data  <= '0;
            output_valid <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            output_valid <= sample_en;
            if (sample_en) begin
                acc         <= acc_clamped;
                output_data <= out_clamped[DATA_W-1:0];
                if (sat_hit) sat_flag <= 1'b1;

                case (state)
                    // The pop sample itself is decay-only.
                    S_IDLE: begin
                        if (!fifo_empty) begin
                            step <= pop_amp >>> RISE_SHIFT;
                            rcnt <= '0;
                            if (fifo_out.delay == '0) begin
                                state <= S_RISE;
                            end else begin
                                state <= S_WAIT;
                                cnt   <= fifo_out.delay - DELAY_W'(1);
                            end
                        end
                    end
                    S_WAIT: begin
                        if (cnt == '0) state <= S_RISE;
                        else           cnt   <= cnt - DELAY_W'(1);
                    end
                    S_RISE: begin
                        if (rcnt == RISE_LAST) state <= S_IDLE;
                        else                   rcnt  <= rcnt + (RISE_SHIFT+1)'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
